// File: rtl/apd_pkg.sv
// -----------------------------------------------------------------------------
// apd_pkg
// Shared definitions for the APD pulse-train generator:
//   - default widths for the pulse-width/dead-time fields and the pulse counter
//   - FSM state encoding (IDLE, HIGH, LOW)
//   - nz(): clamps a zero field to 1 so that a 0 width or dead time still
//     produces a one-cycle phase
// -----------------------------------------------------------------------------
package apd_pkg;

   localparam int unsigned APD_W_W_DEF   = 8;
   localparam int unsigned APD_CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } apd_state_t;

   function automatic int unsigned nz(input int unsigned x);
      return (x == 32'd0) ? 32'd1 : x;
   endfunction

endpackage

// File: rtl/apd_pulse_gen_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that times one HIGH or LOW phase. It is shared by both
// phases: the FSM reloads it with W or D on every phase change.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (count cleared to 0)
//   load   in   load 'value' into the counter on this edge
//   value  in   W_W  phase length in cycles (already clamped to >= 1)
//   last   out  current cycle is the final cycle of the phase (count == 1)
// -----------------------------------------------------------------------------
module phase_timer
   import apd_pkg::*;
#(
   parameter int W_W = APD_W_W_DEF
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [W_W-1:0] value,
   output logic           last
);

   logic [W_W-1:0] r_count;

   // The counter rests at 0 once expired, so a stale 'last' never reappears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (r_count != '0) begin
         r_count <= r_count - W_W'(1);
      end
   end

   // A load of 1 lands here as count == 1, giving a single-cycle phase.
   assign last = (r_count == W_W'(1));

endmodule

// File: rtl/apd_pulse_gen.sv
// -----------------------------------------------------------------------------
// apd_pulse_gen
// Programmable burst generator for APD-style detection pulses. A burst is N
// pulses, each W cycles high followed by D cycles low (the last pulse too, so
// consecutive bursts always honour the dead time).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   request a burst (only looked at while idle)
//   abort          in   cancel the running burst; wins over start
//   pulse_width    in   W_W    high time W (0 behaves as 1)
//   dead_time_APD  in   W_W    low time D after each pulse (0 behaves as 1)
//   pulse_count    in   CNT_W  pulses per burst N (0 gives an immediate done)
//   pulse_out      out  registered pulse output
//   busy           out  burst in progress
//   done           out  one-cycle strobe on completion or abort
//   pulses_sent    out  CNT_W  pulses emitted in the current/last burst
// -----------------------------------------------------------------------------
module apd_pulse_gen
   import apd_pkg::*;
#(
   parameter int W_W   = APD_W_W_DEF,
   parameter int CNT_W = APD_CNT_W_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [W_W-1:0]   pulse_width,
   input  logic [W_W-1:0]   dead_time_APD,
   input  logic [CNT_W-1:0] pulse_count,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulses_sent
);

   apd_state_t       r_state;
   apd_state_t       w_state_nxt;

   logic [W_W-1:0]   r_width;
   logic [W_W-1:0]   r_dead;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_sent;
   logic             r_pulse;
   logic             r_busy;
   logic             r_done;

   logic [W_W-1:0]   w_width_nz;
   logic [W_W-1:0]   w_dead_nz;
   logic [W_W-1:0]   w_load_val;
   logic             w_load;
   logic             w_last;
   logic             w_accept;
   logic             w_inc;
   logic             w_done_nxt;

   // Fields are clamped once at the accept edge and stored clamped.
   assign w_width_nz = W_W'(nz(32'(pulse_width)));
   assign w_dead_nz  = W_W'(nz(32'(dead_time_APD)));

   phase_timer #(
      .W_W (W_W)
   ) u_phase_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load),
      .value (w_load_val),
      .last  (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = r_width;
      w_accept    = 1'b0;
      w_inc       = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               w_accept = 1'b1;
               if (pulse_count != '0) begin
                  w_state_nxt = HIGH;
                  w_load      = 1'b1;
                  w_load_val  = w_width_nz;
                  w_inc       = 1'b1;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end

         HIGH: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else if (w_last) begin
               w_state_nxt = LOW;
               w_load      = 1'b1;
               w_load_val  = r_dead;
            end
         end

         LOW: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else if (w_last) begin
               // r_sent already counts the pulse that just ended.
               if (r_sent == r_num) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = HIGH;
                  w_load      = 1'b1;
                  w_load_val  = r_width;
                  w_inc       = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state
   // register while still coming straight out of flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_width <= '0;
         r_dead  <= '0;
         r_num   <= '0;
         r_sent  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pulse <= (w_state_nxt == HIGH);
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= w_done_nxt;

         if (w_accept) begin
            r_width <= w_width_nz;
            r_dead  <= w_dead_nz;
            r_num   <= pulse_count;
         end

         // Accept clears the count; when the burst is non-empty the first
         // pulse starts on the same edge and counts as 1.
         if (w_accept) begin
            r_sent <= w_inc ? CNT_W'(1) : '0;
         end else if (w_inc) begin
            r_sent <= r_sent + CNT_W'(1);
         end
      end
   end

   assign pulse_out   = r_pulse;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pulses_sent = r_sent;

endmodule

// File: tb/tb_apd_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_apd_pulse_gen
// Directed bench for apd_pulse_gen. A burst-level model predicts the outputs
// for every cycle from (cycles since accept) / (W+D) arithmetic; a compare
// process checks the DUT against it on each falling edge, and the stimulus
// sequence adds hand-computed literal checks at key cycles.
// Inputs are driven 1 time unit after the rising edge; cycle e is the
// interval following rising edge e.
// -----------------------------------------------------------------------------
module tb_apd_pulse_gen;

   localparam int W_W   = 8;
   localparam int CNT_W = 16;

   logic             clk    = 1'b0;
   logic             clk_en = 1'b1;
   logic             rst_n  = 1'b0;
   logic             start  = 1'b0;
   logic             abort  = 1'b0;
   logic [W_W-1:0]   pulse_width   = '0;
   logic [W_W-1:0]   dead_time_APD = '0;
   logic [CNT_W-1:0] pulse_count   = '0;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulses_sent;

   int n_vec  = 0;
   int n_err  = 0;
   int e      = 0;
   bit chk_en = 1'b0;

   // model state
   bit   m_act = 1'b0;
   int   m_s = 0, m_w = 0, m_d = 0, m_n = 0;
   logic exp_pulse = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
   int   exp_sent = 0;

   apd_pulse_gen #(
      .W_W   (W_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .pulse_width   (pulse_width),
      .dead_time_APD (dead_time_APD),
      .pulse_count   (pulse_count),
      .pulse_out     (pulse_out),
      .busy          (busy),
      .done          (done),
      .pulses_sent   (pulses_sent)
   );

   always #5 if (clk_en) clk = ~clk;

   function automatic int nzm(input int x);
      return (x == 0) ? 1 : x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, e, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      int g;
      g = 0;
      while (e < t && g < 1000) begin
         tick();
         g++;
      end
      if (e != t) chk("wait_to", e, t);
   endtask

   task automatic go(input int w, input int d, input int n, output int k);
      pulse_width   = W_W'(w);
      dead_time_APD = W_W'(d);
      pulse_count   = CNT_W'(n);
      start = 1'b1;
      k = e;
      tick();
      start = 1'b0;
   endtask

   task automatic lit(input string tag, input logic p, input logic b, input logic dn, input int s);
      chk({tag, ".pulse"}, pulse_out, p);
      chk({tag, ".busy"},  busy,      b);
      chk({tag, ".done"},  done,      dn);
      chk({tag, ".sent"},  pulses_sent, s);
   endtask

   // Burst-level reference model: one step per rising edge.
   initial forever begin
      int rel, per;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_act = 1'b0; exp_pulse = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_sent = 0;
      end else begin
         e++;
         exp_done = 1'b0;
         if (m_act) begin
            if (abort) begin
               m_act = 1'b0; exp_done = 1'b1; exp_busy = 1'b0; exp_pulse = 1'b0;
            end else begin
               rel = e - m_s;
               per = m_w + m_d;
               if (rel >= m_n * per) begin
                  m_act = 1'b0; exp_done = 1'b1; exp_busy = 1'b0; exp_pulse = 1'b0;
                  exp_sent = m_n;
               end else begin
                  exp_busy  = 1'b1;
                  exp_pulse = ((rel % per) < m_w);
                  exp_sent  = rel / per + 1;
               end
            end
         end else begin
            exp_busy  = 1'b0;
            exp_pulse = 1'b0;
            if (start && !abort) begin
               m_w = nzm(int'(pulse_width));
               m_d = nzm(int'(dead_time_APD));
               m_n = int'(pulse_count);
               m_s = e;
               if (m_n == 0) begin
                  exp_done = 1'b1;
                  exp_sent = 0;
               end else begin
                  m_act = 1'b1; exp_busy = 1'b1; exp_pulse = 1'b1; exp_sent = 1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
         chk("cyc.pulse_out",   pulse_out,   exp_pulse);
         chk("cyc.busy",        busy,        exp_busy);
         chk("cyc.done",        done,        exp_done);
         chk("cyc.pulses_sent", pulses_sent, exp_sent);
      end
   end

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      lit("reset", 1'b0, 1'b0, 1'b0, 0);
      chk_en = 1'b1;
      tick(); tick();

      // W=3 D=5 N=4; fields changed mid-burst must be ignored
      go(3, 5, 4, k);
      lit("A.first", 1'b1, 1'b1, 1'b0, 1);
      wait_to(k + 3);  chk("A.p3",  pulse_out, 1'b1);
      wait_to(k + 4);  chk("A.p4",  pulse_out, 1'b0);
      pulse_width = 8'd1; pulse_count = 16'd1; dead_time_APD = 8'd9;
      wait_to(k + 9);  lit("A.p9", 1'b1, 1'b1, 1'b0, 2);
      wait_to(k + 25); lit("A.p25", 1'b1, 1'b1, 1'b0, 4);
      wait_to(k + 28); chk("A.p28", pulse_out, 1'b0);
      wait_to(k + 32); lit("A.p32", 1'b0, 1'b1, 1'b0, 4);
      wait_to(k + 33); lit("A.done", 1'b0, 1'b0, 1'b1, 4);
      wait_to(k + 34); lit("A.after", 1'b0, 1'b0, 1'b0, 4);
      tick();

      // W=0 D=0 N=3 -> one-cycle pulses at period 2
      go(0, 0, 3, k);
      chk("B.p1", pulse_out, 1'b1);
      wait_to(k + 2); chk("B.p2", pulse_out, 1'b0);
      wait_to(k + 3); chk("B.p3", pulse_out, 1'b1);
      wait_to(k + 5); lit("B.p5", 1'b1, 1'b1, 1'b0, 3);
      wait_to(k + 6); lit("B.p6", 1'b0, 1'b1, 1'b0, 3);
      wait_to(k + 7); lit("B.done", 1'b0, 1'b0, 1'b1, 3);
      tick();

      // N=0 -> immediate done, nothing else
      go(5, 5, 0, k);
      lit("C.done", 1'b0, 1'b0, 1'b1, 0);
      wait_to(k + 2); lit("C.after", 1'b0, 1'b0, 1'b0, 0);
      tick();

      // abort in the 3rd pulse's second high cycle; abort in IDLE first
      abort = 1'b1; tick(); abort = 1'b0;
      go(4, 4, 10, k);
      wait_to(k + 18);
      chk("D.high", pulse_out, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      lit("D.abort", 1'b0, 1'b0, 1'b1, 3);
      wait_to(k + 20); lit("D.after", 1'b0, 1'b0, 1'b0, 3);

      // start while busy ignored; start on the done cycle accepted
      go(2, 3, 2, k);
      wait_to(k + 3);
      pulse_width = 8'd9; pulse_count = 16'd7; start = 1'b1;
      tick();
      start = 1'b0;
      lit("E.ign", 1'b0, 1'b1, 1'b0, 1);
      wait_to(k + 6); lit("E.p6", 1'b1, 1'b1, 1'b0, 2);
      wait_to(k + 11);
      lit("E.done", 1'b0, 1'b0, 1'b1, 2);
      go(1, 2, 1, k);
      lit("E.next", 1'b1, 1'b1, 1'b0, 1);
      tick();
      chk("E.next_low", pulse_out, 1'b0);
      wait_to(k + 4); lit("E.done2", 1'b0, 1'b0, 1'b1, 1);
      tick();

      // asynchronous reset mid-HIGH with the clock stopped
      go(6, 2, 2, k);
      wait_to(k + 3);
      chk("F.high", pulse_out, 1'b1);
      @(negedge clk);
      #1 clk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 lit("F.inrst", 1'b0, 1'b0, 1'b0, 0);
      #10 rst_n = 1'b1;
      #3 lit("F.release", 1'b0, 1'b0, 1'b0, 0);
      clk_en = 1'b1;
      tick(); tick();
      lit("F.idle", 1'b0, 1'b0, 1'b0, 0);
      go(1, 1, 1, k);
      lit("F.restart", 1'b1, 1'b1, 1'b0, 1);
      wait_to(k + 3); lit("F.done", 1'b0, 1'b0, 1'b1, 1);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
